// File: rtl/rx_ctrl_pkg.sv
// Shared types and width helpers for the serial receive control slice.
package rx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK,
    LOAD
  } rx_state_e;

  // Counter width for a count range of n values; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: clk_cnt walks 0..CLKS_PER_BIT-1, bit_cnt counts wraps.
module rx_bit_timer
  import rx_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned SAMPLE_PT    = 5,
  parameter int unsigned DATA_BITS    = 8,
  localparam int unsigned CW = cnt_width(CLKS_PER_BIT),
  localparam int unsigned BW = cnt_width(DATA_BITS + 2)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          enable,
  input  logic          clear,
  output logic          sample_tick,
  output logic [BW-1:0] bit_idx
);

  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SAMPLE_V = CW'(SAMPLE_PT);

  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (enable) begin
      if (clk_cnt == LAST_CLK) begin
        clk_cnt <= '0;
        bit_cnt <= bit_cnt + BW'(1);
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
    end
  end

  assign sample_tick = enable && (clk_cnt == SAMPLE_V);
  assign bit_idx     = bit_cnt;

endmodule

// File: rtl/rx_seq_ctrl.sv
// Receive sequencer: start detect, mid-bit shift strobes, stop check,
// buffer load and the data_ready / overrun / framing status flags.
module rx_seq_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned SAMPLE_PT    = 5,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic stop_bit,
  input  logic data_read,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic overrun_error,
  output logic framing_error
);

  localparam int unsigned BW = cnt_width(DATA_BITS + 2);
  localparam logic [BW-1:0] STOP_IDX = BW'(DATA_BITS + 1);

  rx_state_e     state, state_nxt;
  logic          prev_line;
  logic          start_det;
  logic          sample_tick;
  logic [BW-1:0] bit_idx;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_PT   (SAMPLE_PT),
    .DATA_BITS   (DATA_BITS)
  ) u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (state == RECV),
    .clear      (state != RECV),
    .sample_tick(sample_tick),
    .bit_idx    (bit_idx)
  );

  assign start_det = (state == IDLE) && prev_line && !serial_in;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      prev_line <= 1'b1;
    end else begin
      state     <= state_nxt;
      prev_line <= serial_in;
    end
  end

  always_comb begin
    state_nxt    = state;
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
    case (state)
      IDLE: if (start_det) state_nxt = RECV;
      RECV: begin
        if (sample_tick) begin
          if (bit_idx == '0) begin
            // Line back high at mid start bit: treat as a glitch.
            if (serial_in) state_nxt = IDLE;
          end else begin
            shift_strobe = 1'b1;
            if (bit_idx == STOP_IDX) state_nxt = CHECK;
          end
        end
      end
      CHECK: state_nxt = stop_bit ? LOAD : IDLE;
      LOAD: begin
        load_buffer = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (start_det) framing_error <= 1'b0;
      else if (state == CHECK && !stop_bit) framing_error <= 1'b1;

      // A read coinciding with the load consumes the old word, so the new one stays valid.
      if (state == LOAD) begin
        data_ready <= 1'b1;
        if (data_ready && !data_read) overrun_error <= 1'b1;
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_seq_ctrl.sv
// Self-checking bench for rx_seq_ctrl with a frame-level reference model.
module tb_rx_seq_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic serial_in = 1'b1;
  logic stop_bit = 1'b0;
  logic data_read = 1'b0;
  logic shift_strobe, load_buffer, data_ready, overrun_error, framing_error;

  int checks = 0;
  int failures = 0;

  // Reference model state: the status flags and the external shift register.
  logic       exp_ready = 1'b0;
  logic       exp_ovr = 1'b0;
  logic       exp_fe = 1'b0;
  logic [8:0] sr = '0;

  rx_seq_ctrl #(
    .CLKS_PER_BIT(10),
    .SAMPLE_PT   (5),
    .DATA_BITS   (8)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .stop_bit     (stop_bit),
    .data_read    (data_read),
    .shift_strobe (shift_strobe),
    .load_buffer  (load_buffer),
    .data_ready   (data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    if (shift_strobe) sr = {serial_in, sr[8:1]};
    @(posedge clk);
    #1;
    stop_bit = sr[8];
  endtask

  task automatic check_flags(input string tag);
    checks++;
    if ({data_ready, overrun_error, framing_error} !== {exp_ready, exp_ovr, exp_fe}) begin
      failures++;
      $display("FAIL %s flags rdy/ovr/fe got=%b%b%b exp=%b%b%b", tag,
               data_ready, overrun_error, framing_error, exp_ready, exp_ovr, exp_fe);
    end
  endtask

  // One frame starting at n=0 (cycle E); strobe k expected at E+6+10k, load at E+98.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic rd_in_load);
    logic [9:0] bits;
    logic exp_s, exp_l;
    bits = {stop, data, 1'b0};
    for (int n = 0; n < 104; n++) begin
      serial_in = (n < 100) ? bits[n / 10] : 1'b1;
      data_read = rd_in_load && (n == 98);
      exp_s = (n >= 16) && (n <= 96) && ((n - 16) % 10 == 0);
      exp_l = stop && (n == 98);
      checks++;
      if (shift_strobe !== exp_s) begin
        failures++;
        $display("FAIL strobe n=%0d got=%b exp=%b", n, shift_strobe, exp_s);
      end
      checks++;
      if (load_buffer !== exp_l) begin
        failures++;
        $display("FAIL load n=%0d got=%b exp=%b", n, load_buffer, exp_l);
      end
      if (n == 1) begin
        checks++;
        if (framing_error !== 1'b0) begin
          failures++;
          $display("FAIL fe_clear_on_start got=%b exp=0", framing_error);
        end
      end
      if (n == 98 && stop) begin
        checks++;
        if (sr[7:0] !== data) begin
          failures++;
          $display("FAIL word got=%h exp=%h", sr[7:0], data);
        end
      end
      tick();
    end
    data_read = 1'b0;
    exp_fe = !stop;
    if (stop) begin
      if (exp_ready && !rd_in_load) exp_ovr = 1'b1;
      exp_ready = 1'b1;
    end else if (rd_in_load) begin
      exp_ready = 1'b0;
      exp_ovr   = 1'b0;
    end
    check_flags("frame_end");
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    exp_ready = 1'b0;
    exp_ovr   = 1'b0;
    tick();
    check_flags("after_read");
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({shift_strobe, load_buffer, data_ready, overrun_error, framing_error} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000",
               {shift_strobe, load_buffer, data_ready, overrun_error, framing_error});
    end
    n_rst = 1'b1;
    repeat (3) tick();
    check_flags("post_reset");
  endtask

  task automatic test_frame();
    send_frame(8'hA5, 1'b1, 1'b0);
    read_pulse();
    for (int i = 0; i < 3; i++) begin
      send_frame(8'($urandom), 1'b1, 1'b0);
      read_pulse();
    end
  endtask

  task automatic test_glitch();
    int strobes = 0;
    int loads = 0;
    for (int n = 0; n < 40; n++) begin
      serial_in = (n < 3) ? 1'b0 : 1'b1;
      if (shift_strobe) strobes++;
      if (load_buffer) loads++;
      tick();
    end
    checks++;
    if (strobes != 0 || loads != 0) begin
      failures++;
      $display("FAIL glitch strobes/loads got=%0d/%0d exp=0/0", strobes, loads);
    end
    check_flags("glitch");
  endtask

  task automatic test_framing();
    send_frame(8'($urandom), 1'b1, 1'b0);
    send_frame(8'($urandom), 1'b0, 1'b0);
    send_frame(8'($urandom), 1'b1, 1'b0);
    read_pulse();
  endtask

  task automatic test_back_to_back();
    send_frame(8'($urandom), 1'b1, 1'b0);
    send_frame(8'($urandom), 1'b1, 1'b0);
    checks++;
    if (overrun_error !== 1'b1) begin
      failures++;
      $display("FAIL overrun got=%b exp=1", overrun_error);
    end
    read_pulse();
  endtask

  task automatic test_read_in_load();
    send_frame(8'($urandom), 1'b1, 1'b0);
    send_frame(8'($urandom), 1'b1, 1'b1);
    read_pulse();
  endtask

  task automatic test_stuck_low();
    int strobes = 0;
    int loads = 0;
    for (int n = 0; n < 250; n++) begin
      serial_in = 1'b0;
      if (shift_strobe) strobes++;
      if (load_buffer) loads++;
      tick();
    end
    serial_in = 1'b1;
    repeat (3) tick();
    exp_fe = 1'b1;
    checks++;
    if (strobes != 9 || loads != 0) begin
      failures++;
      $display("FAIL stuck_low strobes/loads got=%0d/%0d exp=9/0", strobes, loads);
    end
    check_flags("stuck_low");
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits;
    send_frame(8'($urandom), 1'b1, 1'b0);
    bits = {1'b1, 8'($urandom), 1'b0};
    for (int n = 0; n < 50; n++) begin
      serial_in = bits[n / 10];
      tick();
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({shift_strobe, load_buffer, data_ready, overrun_error, framing_error} !== 5'b0) begin
      failures++;
      $display("FAIL midframe_reset got=%b exp=00000",
               {shift_strobe, load_buffer, data_ready, overrun_error, framing_error});
    end
    exp_ready = 1'b0;
    exp_ovr   = 1'b0;
    exp_fe    = 1'b0;
    serial_in = 1'b1;
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (3) tick();
    check_flags("after_midframe_reset");
    send_frame(8'($urandom), 1'b1, 1'b0);
    read_pulse();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_read_in_load();
    test_stuck_low();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_seq_ctrl.md
Name: rx_seq_ctrl

Overview:
Receive control unit that sequences a serial-to-parallel shift register for an asynchronous serial receiver. It detects a start bit, times each bit period, and drives the register's shift enable at mid-bit. After the frame it checks the stop bit, strobes the received word into the output buffer, and keeps the data_ready, overrun and framing status flags.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit period; must be >= 4.
SAMPLE_PT, 5, cycle index within a bit period (0..CLKS_PER_BIT-1) at which the line is sampled.
DATA_BITS, 8, data bits per frame; the external shift register is DATA_BITS+1 wide (data plus stop bit).

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
serial_in  input  1  receive line, already synchronized; idle high
stop_bit  input  1  MSB of the external shift register (sampled stop bit)
data_read  input  1  host acknowledges and consumes the buffered word (1-cycle pulse)
shift_strobe  output  1  shift enable to the shift register
load_buffer  output  1  1-cycle pulse that copies the shift-register data bits into the output buffer
data_ready  output  1  buffered word valid
overrun_error  output  1  new word loaded while previous word was unread
framing_error  output  1  last frame had stop bit == 0

Behaviour:
- Reset (async, n_rst=0): state=IDLE, clk_cnt=0, bit_cnt=0, prev_line=1. All outputs 0.
- Start detect: in IDLE, start_det = prev_line & ~serial_in. prev_line <= serial_in every cycle. Call that cycle E.
- IDLE: on start_det -> RECV, clk_cnt<=0, bit_cnt<=0, framing_error<=0.
- RECV: clk_cnt increments every cycle and wraps from CLKS_PER_BIT-1 to 0. bit_cnt increments on each wrap.
  - bit_cnt=0 (start bit): at clk_cnt==SAMPLE_PT, if serial_in==1 this is a false start -> IDLE, with no strobe and no flag change.
  - bit_cnt 1..DATA_BITS+1: shift_strobe=1 for exactly the cycle where clk_cnt==SAMPLE_PT (Moore, decoded from state and counters).
  - On the strobe with bit_cnt==DATA_BITS+1 -> CHECK.
- Timing: strobe k (k=1..DATA_BITS+1) is in cycle E+1+k*CLKS_PER_BIT+SAMPLE_PT.
- CHECK (1 cycle; the register has already updated): stop_bit==1 -> LOAD; stop_bit==0 -> framing_error<=1, then IDLE with no load.
- LOAD (1 cycle): load_buffer=1, data_ready<=1, then IDLE.
  - If data_ready==1 and data_read==0 in this cycle, overrun_error<=1.
  - If data_read==1 in the LOAD cycle, data_ready stays 1 and overrun is not set.
- data_read outside LOAD clears data_ready and overrun_error on the next edge.
- framing_error holds until the next start_det.
- The remaining half of the stop bit is ignored. IDLE needs a high-to-low edge to restart, so a line stuck low does not retrigger.
- shift_strobe and load_buffer are never asserted in the same cycle, and never in IDLE.
- Reset mid-frame returns to IDLE immediately with all outputs 0, regardless of counter values.
- Counter widths: clk_cnt is $clog2(CLKS_PER_BIT) bits; bit_cnt is $clog2(DATA_BITS+2) bits; no overflow is possible.

Decomposition:
- Package rx_ctrl_pkg: state enum {IDLE, RECV, CHECK, LOAD} and a localparam helper for the counter widths.
- One natural sub-module, rx_bit_timer, holding clk_cnt and bit_cnt. Interface: enable, clear, sample_tick, bit_idx. The FSM, start detect and flags stay in rx_seq_ctrl.

Test Plan:
1. Defaults; frame 0 | 0xA5 LSB-first | stop=1, start edge at cycle E -> shift_strobe at E+16, E+26 ... E+96 (9 strobes); load_buffer at E+98; data_ready=1; no errors.
2. Line low for 3 cycles only (glitch) -> start sampled 1 at E+6 -> IDLE; zero strobes; flags unchanged.
3. Frame with stop=0 (stop_bit input 0 in CHECK) -> framing_error=1 at E+98; no load_buffer; data_ready unchanged; next valid start edge clears framing_error.
4. Two valid frames back-to-back, no data_read -> second load_buffer sets overrun_error=1 and data_ready stays 1; a data_read pulse then clears both.
5. data_read asserted exactly in the LOAD cycle of frame 2 with data_ready=1 -> data_ready=1, overrun_error=0.
6. n_rst pulsed low at E+50 -> all outputs 0 immediately, state IDLE; a subsequent full frame is received correctly.
